vec_seq_ctrl: RTL and testbench

Vector issue sequencer for the 5-stage vector pipeline. It accepts a decoded vector instruction from ID and holds the IF/ID front end while it issues the instruction over the 8-lane vector ALU. Each issue is one beat; there are ceil(vlen/8) beats. After the last beat it drains the pipeline so a dependent instruction cannot read a vector register before write-back, since there is no vector forwarding. The per-beat element counter feeds ID_EXE, the tail lane mask feeds EXE_stage, and the branch signal PCSrc aborts the sequence.

---
 rtl/vec_seq_ctrl.sv | 84 ++++++++
 tb/tb_vec_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: issues a vector instruction as 8-lane beats, then drains the pipeline before releasing IF/ID
module vec_seq_ctrl #(
    parameter int LANES     = 8,
    parameter int CNT_W     = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      vlen,
    input  logic             flush,
    output logic             stall,
    output logic             beat_valid,
    output logic [CNT_W-1:0] cnt,
    output logic [LANES-1:0] lane_mask,
    output logic             last,
    output logic             done,
    output logic             busy
);
    localparam int RW   = $clog2(LANES);
    localparam int VMAX = LANES * (2 ** CNT_W);
    localparam int VW   = $clog2(VMAX) + 1;
    localparam int DW   = $clog2(DRAIN_CYC + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    logic [1:0]       state;
    logic [CNT_W-1:0] last_idx;
    logic [RW-1:0]    rem;
    logic [DW-1:0]    dcnt;
    logic             zdone;
    logic [VW-1:0]    vclamp;
    logic [VW-1:0]    vm1;
    logic             accept;
    logic             in_run;
    // element count clamped to what CNT_W beats can cover, plus all state decodes
    always_comb begin
        vclamp     = (vlen > 32'(VMAX)) ? VW'(VMAX) : vlen[VW-1:0];
        vm1        = vclamp - 1'b1;
        accept     = (state == IDLE) && start && (vlen != '0) && !flush;
        in_run     = state == RUN;
        stall      = accept || in_run || ((state == DRAIN) && (dcnt != '0));
        beat_valid = in_run;
        last       = in_run && (cnt == last_idx);
        lane_mask  = !in_run ? '0 : (last && rem != '0) ? ~({LANES{1'b1}} << rem) : '1;
        done       = zdone || ((state == DRAIN) && (dcnt == '0));
        busy       = state != IDLE;
    end
    // sequencer: flush wins over everything; a zero-length start only produces a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            last_idx <= '0;
            rem      <= '0;
            zdone    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            zdone <= 1'b0;
        end else begin
            zdone <= (state == IDLE) && start && (vlen == '0);
            if (accept) begin
                state    <= RUN;
                cnt      <= '0;
                last_idx <= CNT_W'(vm1 >> RW);
                rem      <= vclamp[RW-1:0];
            end else if (in_run) begin
                if (last) begin
                    state <= DRAIN;
                    cnt   <= '0;
                    dcnt  <= DW'(DRAIN_CYC - 1);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == DRAIN) begin
                if (dcnt == '0) state <= IDLE;
                else dcnt <= dcnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: scoreboard bench for vec_seq_ctrl with directed and random vector lengths
module tb_vec_seq_ctrl;
    localparam int D = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] vlen = '0;
    logic        stall, beat_valid, last, done, busy;
    logic [4:0]  cnt;
    logic [7:0]  lane_mask;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int         cyc;
        logic       bv;
        logic [4:0] cnt;
        logic [7:0] mask;
        logic       last;
        logic       dn;
    } ev_t;
    ev_t sbq[$];

    vec_seq_ctrl #(.LANES(8), .CNT_W(5), .DRAIN_CYC(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vlen(vlen), .flush(flush),
        .stall(stall), .beat_valid(beat_valid), .cnt(cnt), .lane_mask(lane_mask),
        .last(last), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // monitor: every cycle the DUT shows a beat or a done, it must match the oldest expectation
    always @(negedge clk) begin
        ev_t e;
        if (beat_valid || done) begin
            if (sbq.size() == 0)
                chk("unexpected_out", {beat_valid, cnt, lane_mask, last, done}, 64'd0);
            else begin
                e = sbq.pop_front();
                chk("out", {cyc, beat_valid, cnt, lane_mask, last, done},
                    {e.cyc, e.bv, e.cnt, e.mask, e.last, e.dn});
            end
        end
    end

    // reference: a start in cycle c0 gives beats at c0+1.. and done D cycles after the last beat
    task automatic push_txn(input int c0, input logic [31:0] v, output int nb);
        int cl;
        int act;
        ev_t e;
        cl = (v > 32'd256) ? 256 : int'(v);
        nb = (cl + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            act = (cl - 8 * k < 8) ? cl - 8 * k : 8;
            e = '{c0 + 1 + k, 1'b1, 5'(k), 8'((1 << act) - 1), k == nb - 1, 1'b0};
            sbq.push_back(e);
        end
        e = '{(nb == 0) ? c0 + 1 : c0 + nb + D, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1};
        sbq.push_back(e);
    endtask

    // fl: offset (1-based cycle after start) in which flush is driven, 0 for none
    task automatic run_txn(input logic [31:0] v, input int fl);
        int c0, nb;
        c0 = cyc;
        start = 1'b1;
        vlen = v;
        flush = 1'b0;
        push_txn(c0, v, nb);
        @(negedge clk);
        chk("busy_at_start", busy, 0);
        chk("stall_at_start", stall, v != 0);
        @(posedge clk); #1;
        start = 1'b0;
        if (nb == 0) return;
        for (int t = 1; t <= nb + D; t++) begin
            start = 1'($urandom);
            vlen = $urandom;
            flush = (t == fl);
            @(negedge clk);
            chk("busy_run", busy, 1);
            chk("stall_run", stall, t < nb + D);
            if (flush)
                while (sbq.size() > 0 && sbq[$].cyc > c0 + t) void'(sbq.pop_back());
            @(posedge clk); #1;
            if (t == fl) break;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            vlen = $urandom;
            flush = 1'($urandom);
            @(negedge clk);
            chk("stall_idle", stall, 0);
            chk("busy_idle", busy, 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    function automatic logic [31:0] pick_vlen();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(1, 8));
            2: return 32'(8 * $urandom_range(1, 32));
            3: return 32'($urandom_range(1, 256));
            4: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'($urandom_range(257, 5000));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c0, nb, fl;
        logic [31:0] v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {beat_valid, cnt, lane_mask, last, done, busy, stall}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        run_txn(32'd20, 0);
        idle(2);
        run_txn(32'd16, 0);
        run_txn(32'd0, 0);
        idle(1);
        run_txn(32'd1000, 0);
        run_txn(32'd40, 3);
        run_txn(32'd8, 0);
        idle(1);
        start = 1'b1;
        vlen = 32'd24;
        flush = 1'b1;
        @(negedge clk);
        chk("stall_start_flush", stall, 0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("busy_after_start_flush", busy, 0);
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1;
        vlen = 32'd24;
        push_txn(c0, 32'd24, nb);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {beat_valid, cnt, lane_mask, last, done, busy, stall}, 64'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        repeat (60) begin
            idle($urandom_range(0, 2));
            v = pick_vlen();
            nb = ((v > 32'd256) ? 256 : int'(v) + 7) / 8;
            if (v > 32'd256) nb = 32;
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb + D - 1) : 0;
            run_txn(v, fl);
        end
        idle(D + 2);
        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
